// File: rtl/ysyx_23060075_mem_arb_pkg.sv
// rtl/ysyx_23060075_mem_arb_pkg.sv - shared widths, state/owner encodings and alignment helper for the memory arbiter
package ysyx_23060075_mem_arb_pkg;

    localparam int ISA_WIDTH       = 32;
    localparam int MEM_MASK_WIDTH  = ISA_WIDTH / 8;
    localparam int TIMEOUT_CYC_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Size 3 is handled like a word access.
    function automatic logic ls_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_23060075_rr_arb2.sv
// rtl/ysyx_23060075_rr_arb2.sv - two-way round-robin picker, one-hot grant, purely combinational
module ysyx_23060075_rr_arb2
    import ysyx_23060075_mem_arb_pkg::*;
(
    input  logic       req_if,
    input  logic       req_ls,
    input  owner_e     last_grant,
    output logic [1:0] grant
);

    // On a tie the requester that was not served last wins.
    assign grant[0] = req_if && (!req_ls || (last_grant == OWN_LS));
    assign grant[1] = req_ls && (!req_if || (last_grant == OWN_IF));

endmodule

// File: rtl/ysyx_23060075_mem_arb.sv
// rtl/ysyx_23060075_mem_arb.sv - single-outstanding arbiter sharing one memory port between IF and LS
module ysyx_23060075_mem_arb
    import ysyx_23060075_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ISA_WIDTH,
    parameter int DATA_W      = ISA_WIDTH,
    parameter int MASK_W      = MEM_MASK_WIDTH,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [1:0]        ls_size,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [MASK_W-1:0] ls_mask,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    localparam int WD_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_e        state, state_nxt;
    owner_e            owner_q, last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, rsp_data;
    logic [MASK_W-1:0] mask_q;
    logic [WD_W-1:0]   wd_cnt;
    logic [1:0]        grant;
    logic              accept_if, accept_ls, accept, misaligned, wd_hit, rsp_fire;

    ysyx_23060075_rr_arb2 u_rr (
        .req_if     (if_req_valid),
        .req_ls     (ls_req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Readies are gated by reset so nothing looks accepted while held in reset.
    assign accept_if  = rst && (state == ST_IDLE) && grant[0];
    assign accept_ls  = rst && (state == ST_IDLE) && grant[1];
    assign accept     = accept_if || accept_ls;
    assign misaligned = accept_if ? (if_addr[1:0] != 2'b00) : ls_misaligned(ls_size, ls_addr[1:0]);
    assign wd_hit     = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = misaligned ? ST_ERR : ST_ISSUE;
            ST_ISSUE: begin
                if (wd_hit)             state_nxt = ST_ERR;
                else if (mem_req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) state_nxt = ST_RESP;
                else if (wd_hit)   state_nxt = ST_ERR;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner_q    <= OWN_IF;
            last_grant <= OWN_LS;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            mask_q     <= '0;
            rdata_q    <= '0;
            wd_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (accept_if) begin
                owner_q    <= OWN_IF;
                last_grant <= OWN_IF;
                addr_q     <= if_addr;
                wen_q      <= 1'b0;
                wdata_q    <= '0;
                mask_q     <= '1;
            end else if (accept_ls) begin
                owner_q    <= OWN_LS;
                last_grant <= OWN_LS;
                addr_q     <= ls_addr;
                wen_q      <= ls_wen;
                wdata_q    <= ls_wdata;
                mask_q     <= ls_wen ? ls_mask : '1;
            end
            if ((state == ST_WAIT) && mem_rsp_valid) rdata_q <= mem_rsp_data;
            if ((state == ST_ISSUE) || (state == ST_WAIT)) wd_cnt <= wd_cnt + 1'b1;
            else                                           wd_cnt <= '0;
        end
    end

    assign mem_req_valid = (state == ST_ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_mask      = mask_q;

    // Stores and error responses return zero data.
    assign rsp_fire     = (state == ST_RESP) || (state == ST_ERR);
    assign rsp_data     = ((state == ST_RESP) && !wen_q) ? rdata_q : '0;
    assign if_req_ready = accept_if;
    assign ls_req_ready = accept_ls;
    assign if_rsp_valid = rsp_fire && (owner_q == OWN_IF);
    assign ls_rsp_valid = rsp_fire && (owner_q == OWN_LS);
    assign if_rsp_err   = (state == ST_ERR) && (owner_q == OWN_IF);
    assign ls_rsp_err   = (state == ST_ERR) && (owner_q == OWN_LS);
    assign if_rsp_data  = (owner_q == OWN_IF) ? rsp_data : '0;
    assign ls_rsp_data  = (owner_q == OWN_LS) ? rsp_data : '0;

endmodule

// File: tb/tb_ysyx_23060075_mem_arb.sv
// tb/tb_ysyx_23060075_mem_arb.sv - scoreboard bench for the IF/LS memory arbiter
module tb_ysyx_23060075_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_addr = '0, if_rsp_data;
    logic        ls_req_valid = 1'b0, ls_req_ready, ls_wen = 1'b0, ls_rsp_valid, ls_rsp_err;
    logic [1:0]  ls_size = 2'd2;
    logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rsp_data;
    logic [3:0]  ls_mask = '0;
    logic        mem_req_valid, mem_req_ready = 1'b1, mem_wen, mem_rsp_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data = '0;
    logic [3:0]  mem_mask;

    typedef struct {
        bit          owner;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0, errors = 0, cyc = 0;
    int          rsp_delay = 0, mem_req_count = 0, cap_cyc = 0, acc = 0, n0 = 0;
    logic [31:0] mem_word = '0, cap_addr = '0, cap_wdata = '0;
    logic        cap_wen = 1'b0;
    logic [3:0]  cap_mask = '0;
    bit          got;

    ysyx_23060075_mem_arb dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_size(ls_size), .ls_wdata(ls_wdata), .ls_mask(ls_mask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_ctrl"}, {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_err,
                              ls_rsp_err, mem_req_valid, mem_wen, mem_mask}, 64'd0);
        chk({name, "_data"}, if_rsp_data | ls_rsp_data | mem_addr | mem_wdata, 64'd0);
    endtask

    // Memory responder: captures the request at handshake and answers after rsp_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                mem_req_count++;
                cap_cyc   = cyc;
                cap_addr  = mem_addr;
                cap_wen   = mem_wen;
                cap_wdata = mem_wdata;
                cap_mask  = mem_mask;
                @(posedge clk);
                repeat (rsp_delay) @(posedge clk);
                #1;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word;
                @(posedge clk);
                #1;
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
            end
        end
    end

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (if_rsp_valid || ls_rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: if_valid=%0b ls_valid=%0b at cycle %0d, none expected",
                         if_rsp_valid, ls_rsp_valid, cyc);
            end else begin
                e = exp_q.pop_front();
                if ((if_rsp_valid && ls_rsp_valid) ||
                    (ls_rsp_valid != e.owner) ||
                    ((e.owner ? ls_rsp_data : if_rsp_data) !== e.data) ||
                    ((e.owner ? ls_rsp_err : if_rsp_err) !== e.err) ||
                    ((e.owner ? {if_rsp_err, if_rsp_data} : {ls_rsp_err, ls_rsp_data}) !== 33'd0) ||
                    ((e.cyc >= 0) && (e.cyc != cyc))) begin
                    errors++;
                    $display("FAIL rsp: got if(v=%0b d=%h e=%0b) ls(v=%0b d=%h e=%0b) cyc=%0d; expected owner=%0d d=%h e=%0b cyc=%0d",
                             if_rsp_valid, if_rsp_data, if_rsp_err, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
                             cyc, e.owner, e.data, e.err, e.cyc);
                end
            end
        end
    end

    task automatic issue(input bit own, input logic [31:0] addr, input bit wen, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [3:0] mask, input logic [31:0] exp_data,
                         input bit exp_err, input int lat, output int acc_cyc);
        bit ok = 1'b0;
        if (!own) begin
            if_req_valid = 1'b1;
            if_addr      = addr;
        end else begin
            ls_req_valid = 1'b1;
            ls_addr      = addr;
            ls_wen       = wen;
            ls_size      = size;
            ls_wdata     = wdata;
            ls_mask      = mask;
        end
        acc_cyc = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((!own && if_req_ready) || (own && ls_req_ready)) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: owner %0d addr %h never got ready", own, addr);
        end else begin
            exp_q.push_back(exp_t'{own, exp_data, exp_err, (lat < 0) ? -1 : acc_cyc + lat});
        end
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with both requesters already valid: nothing may be accepted.
        if_req_valid = 1'b1;
        if_addr      = 32'h8000_0100;
        ls_req_valid = 1'b1;
        ls_addr      = 32'h8000_2000;
        ls_wen       = 1'b0;
        ls_size      = 2'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Round-robin alternation, IF first after reset.
        mem_word = 32'hcafe_f00d;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (if_req_ready || ls_req_ready) got = 1'b1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL arb_accept_timeout: transaction %0d not accepted", t);
            end else begin
                chk("arb_grant", {if_req_ready, ls_req_ready}, (t % 2 == 0) ? 2'b10 : 2'b01);
                exp_q.push_back(exp_t'{ls_req_ready, 32'hcafe_f00d, 1'b0, cyc + 3});
            end
            @(posedge clk);
        end
        #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        wait_drain(20);

        // Plain fetch on the minimum-latency path.
        mem_word = 32'h0000_0413;
        issue(1'b0, 32'h8000_0000, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0000_0413, 1'b0, 3, acc);
        wait_drain(20);
        chk("if_mem_addr", cap_addr, 32'h8000_0000);
        chk("if_mem_wen", cap_wen, 1'b0);
        chk("if_mem_mask", cap_mask, 4'b1111);
        chk("if_issue_cycle", cap_cyc, acc + 1);

        // Half-word store: fields pass through, response data is zero.
        mem_word = 32'h1111_1111;
        issue(1'b1, 32'h8000_1004, 1'b1, 2'd1, 32'hdead_beef, 4'b0011, 32'h0, 1'b0, 3, acc);
        wait_drain(20);
        chk("st_mem_addr", cap_addr, 32'h8000_1004);
        chk("st_mem_wen", cap_wen, 1'b1);
        chk("st_mem_mask", cap_mask, 4'b0011);
        chk("st_mem_wdata", cap_wdata, 32'hdead_beef);

        // Misaligned accesses never reach memory and error in the next cycle.
        n0 = mem_req_count;
        issue(1'b1, 32'h8000_1002, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, 1'b1, 1, acc);
        wait_drain(10);
        issue(1'b1, 32'h8000_1001, 1'b0, 2'd1, 32'h0, 4'h0, 32'h0, 1'b1, 1, acc);
        wait_drain(10);
        issue(1'b1, 32'h8000_1002, 1'b0, 2'd3, 32'h0, 4'h0, 32'h0, 1'b1, 1, acc);
        wait_drain(10);
        issue(1'b0, 32'h8000_0002, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, 1'b1, 1, acc);
        wait_drain(10);
        chk("misaligned_no_mem_req", mem_req_count, n0);

        // Byte at odd address and aligned half load are legal.
        mem_word = 32'h0000_00a5;
        issue(1'b1, 32'h8000_1003, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0000_00a5, 1'b0, 3, acc);
        wait_drain(20);
        mem_word = 32'h0000_beef;
        issue(1'b1, 32'h8000_1006, 1'b0, 2'd1, 32'h0, 4'h0, 32'h0000_beef, 1'b0, 3, acc);
        wait_drain(20);
        chk("legal_mem_reqs", mem_req_count, n0 + 2);

        // Watchdog: memory never accepts, error 256 cycles after entering ISSUE.
        mem_req_ready = 1'b0;
        issue(1'b0, 32'h8000_0400, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, 1'b1, 257, acc);
        wait_drain(300);
        chk("timeout_back_idle", mem_req_valid, 1'b0);
        mem_req_ready = 1'b1;

        // Reset in WAIT abandons the transaction; the late memory response is ignored.
        rsp_delay = 5;
        mem_word  = 32'hbad0_bad0;
        issue(1'b0, 32'h8000_0200, 1'b0, 2'd2, 32'h0, 4'h0, 32'hbad0_bad0, 1'b0, -1, acc);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk_zero_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rsp_delay = 0;
        mem_word  = 32'h1234_5678;
        issue(1'b0, 32'h8000_0300, 1'b0, 2'd2, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3, acc);
        wait_drain(20);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
